// File: rtl/rv32i_hpm_counter_file.sv
// rv32i_hpm_counter_file: RV32 mcycle/minstret/mhpmcounterN file with event selectors, mcountinhibit and user shadows.
// Latency: a CSR access in cycle T returns CsrRdData/CsrRdValid/CsrIllegal in T+1; counters step every cycle.
// Backpressure: none, one access accepted every cycle. Macro RV32_HPM_OVF_IRQ_EN adds overflow flags (mhpmevent[31]) and HpmIrq.
module rv32i_hpm_counter_file #(
    parameter int NUM_HPM    = 2,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 64
) (
    input  logic                  Clock,
    input  logic                  Rst_N,
    input  logic                  CsrRdEn,
    input  logic                  CsrWrEn,
    input  logic [1:0]            CsrOp,
    input  logic [11:0]           CsrAddr,
    input  logic [31:0]           CsrWrData,
    input  logic                  InstrRetired,
    input  logic [NUM_EVENTS-1:0] EventVec,
    output logic [31:0]           CsrRdData,
    output logic                  CsrRdValid,
    output logic                  CsrIllegal,
    output logic                  HpmIrq
);

    // Implemented inhibit bits: CY(0), IR(2) and one per hpm counter starting at bit 3.
    localparam logic [31:0] INH_MASK = 32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
`ifdef RV32_HPM_OVF_IRQ_EN
    localparam logic [31:0] EVT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EVT_MASK = 32'h7FFF_FFFF;
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic [CNT_W-1:0] hpm_q [NUM_HPM];
    logic [CNT_W-1:0] hpm_d [NUM_HPM];
    logic [31:0]      evt_q [NUM_HPM];
    logic [31:0]      evt_d [NUM_HPM];
    logic [31:0]      inhibit_q, inhibit_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             illegal_q, illegal_d;

    logic             access, addr_hi, is_cnt_m, is_cnt_u, is_ctl, is_inh, is_evt;
    logic             illegal, do_wr, wr_cnt;
    logic [4:0]       idx;
    logic [63:0]      cnt_sel;
    logic [31:0]      evt_sel, rd_val, new_val;
    logic [NUM_HPM-1:0] hpm_inc;
    logic [NUM_HPM-1:0] hpm_wr;

    // Next counter value: a write replaces only the addressed half and suppresses that cycle's increment.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur, input logic inc,
                                                  input logic wr_lo, input logic wr_hi, input logic [31:0] nv);
        logic [CNT_W-1:0] res;
        res = cur;
        if (wr_lo)
            res = {cur[CNT_W-1:32], nv};
        else if (wr_hi)
            res = {nv[CNT_W-33:0], cur[31:0]};
        else if (inc)
            res = cur + CNT_ONE;
        return res;
    endfunction

    // Address decode, legality, read mux (pre-update value) and read-modify-write operand.
    always_comb begin
        access   = CsrRdEn | CsrWrEn;
        idx      = CsrAddr[4:0];
        addr_hi  = CsrAddr[7];
        is_cnt_m = (CsrAddr[11:8] == 4'hB) && (CsrAddr[6:5] == 2'b00) && (idx != 5'd1);
        is_cnt_u = (CsrAddr[11:8] == 4'hC) && (CsrAddr[6:5] == 2'b00) && (idx != 5'd1);
        is_ctl   = (CsrAddr[11:5] == 7'h19) && (idx != 5'd1) && (idx != 5'd2);
        is_inh   = is_ctl && (idx == 5'd0);
        is_evt   = is_ctl && (idx >= 5'd3);
        illegal  = access && (!(is_cnt_m || is_cnt_u || is_ctl) || (CsrWrEn && is_cnt_u) || (CsrOp == 2'b11));

        cnt_sel = '0;
        evt_sel = '0;
        if (idx == 5'd0)
            cnt_sel = 64'(mcycle_q);
        if (idx == 5'd2)
            cnt_sel = 64'(minstret_q);
        for (int i = 0; i < NUM_HPM; i++) begin
            if (idx == 5'(i + 3)) begin
                cnt_sel = 64'(hpm_q[i]);
                evt_sel = evt_q[i];
            end
        end

        rd_val = '0;
        if (is_cnt_m || is_cnt_u)
            rd_val = addr_hi ? cnt_sel[63:32] : cnt_sel[31:0];
        else if (is_inh)
            rd_val = inhibit_q;
        else if (is_evt)
            rd_val = evt_sel;

        case (CsrOp)
            2'b00:   new_val = CsrWrData;
            2'b01:   new_val = rd_val | CsrWrData;
            2'b10:   new_val = rd_val & ~CsrWrData;
            default: new_val = rd_val;
        endcase

        // RS/RC with a zero operand is a pure read.
        do_wr  = access && CsrWrEn && !illegal && ((CsrOp == 2'b00) || (CsrWrData != 32'd0));
        wr_cnt = do_wr && is_cnt_m;
    end

    // Counter, selector and inhibit next state; response registers.
    always_comb begin
        mcycle_d   = cnt_next(mcycle_q, !inhibit_q[0],
                              wr_cnt && !addr_hi && (idx == 5'd0), wr_cnt && addr_hi && (idx == 5'd0), new_val);
        minstret_d = cnt_next(minstret_q, InstrRetired && !inhibit_q[2],
                              wr_cnt && !addr_hi && (idx == 5'd2), wr_cnt && addr_hi && (idx == 5'd2), new_val);
        hpm_inc = '0;
        hpm_wr  = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if ((evt_q[i][4:0] == 5'(e + 1)) && EventVec[e])
                    hpm_inc[i] = 1'b1;
            end
            hpm_inc[i] = hpm_inc[i] && !inhibit_q[i + 3];
            hpm_wr[i]  = wr_cnt && (idx == 5'(i + 3));
            hpm_d[i]   = cnt_next(hpm_q[i], hpm_inc[i], hpm_wr[i] && !addr_hi, hpm_wr[i] && addr_hi, new_val);

            evt_d[i] = evt_q[i];
`ifdef RV32_HPM_OVF_IRQ_EN
            // Wrap 2^CNT_W-1 -> 0 raises the overflow flag.
            if (hpm_inc[i] && !hpm_wr[i] && (hpm_q[i] == '1))
                evt_d[i][31] = 1'b1;
`endif
            // Software write to the selector wins over a same-cycle overflow.
            if (do_wr && is_evt && (idx == 5'(i + 3)))
                evt_d[i] = new_val & EVT_MASK;
        end

        inhibit_d = inhibit_q;
        if (do_wr && is_inh)
            inhibit_d = new_val & INH_MASK;

        rd_valid_d = access;
        illegal_d  = illegal;
        rd_data_d  = (access && !illegal) ? rd_val : 32'd0;
    end

    // State and response registers.
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inhibit_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= '0;
                evt_q[i] <= '0;
            end
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inhibit_q  <= inhibit_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            illegal_q  <= illegal_d;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= hpm_d[i];
                evt_q[i] <= evt_d[i];
            end
        end
    end

    assign CsrRdData  = rd_data_q;
    assign CsrRdValid = rd_valid_q;
    assign CsrIllegal = illegal_q;

`ifdef RV32_HPM_OVF_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt request is the OR of all overflow flags, one cycle behind them.
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NUM_HPM; i++)
            irq_d = irq_d | evt_q[i][31];
    end

    // Interrupt request register.
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign HpmIrq = irq_q;
`else
    assign HpmIrq = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_hpm_counter_file.sv
// tb_rv32i_hpm_counter_file: directed scenarios plus random CSR traffic against a cycle-level reference model.
// Latency: responses are checked 1 ns after the edge that registers them.
// Backpressure: none; stimulus issues at most one access per cycle.
module tb_rv32i_hpm_counter_file;

    localparam int NH = 2;
    localparam int NE = 8;
    localparam int CW = 64;

    logic          Clock;
    logic          Rst_N;
    logic          CsrRdEn;
    logic          CsrWrEn;
    logic [1:0]    CsrOp;
    logic [11:0]   CsrAddr;
    logic [31:0]   CsrWrData;
    logic          InstrRetired;
    logic [NE-1:0] EventVec;
    logic [31:0]   CsrRdData;
    logic          CsrRdValid;
    logic          CsrIllegal;
    logic          HpmIrq;

    rv32i_hpm_counter_file #(.NUM_HPM(NH), .NUM_EVENTS(NE), .CNT_W(CW)) dut (
        .Clock(Clock), .Rst_N(Rst_N), .CsrRdEn(CsrRdEn), .CsrWrEn(CsrWrEn), .CsrOp(CsrOp),
        .CsrAddr(CsrAddr), .CsrWrData(CsrWrData), .InstrRetired(InstrRetired), .EventVec(EventVec),
        .CsrRdData(CsrRdData), .CsrRdValid(CsrRdValid), .CsrIllegal(CsrIllegal), .HpmIrq(HpmIrq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state indexed by CSR number.
    logic [63:0] m_cnt [32];
    logic [31:0] m_evt [32];
    logic [31:0] m_inh;
    logic [31:0] inh_mask;

    function automatic bit m_impl(input int n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NH);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 32; k++) begin
            m_cnt[k] = '0;
            m_evt[k] = '0;
        end
        m_inh = '0;
    endtask

    // One clock: drive an access, advance the model at the edge, compare the registered response.
    task automatic step(input bit rd, input bit wr, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input bit ir, input logic [NE-1:0] ev);
        logic [31:0] old, nv;
        logic [7:0]  lo;
        bit          acc, leg, is_cnt, hi, dowr;
        int          n, e;
        bit          inc [32];
        CsrRdEn = rd; CsrWrEn = wr; CsrOp = op; CsrAddr = addr; CsrWrData = wd;
        InstrRetired = ir; EventVec = ev;

        acc = rd | wr; leg = 0; is_cnt = 0; old = 0;
        lo = addr[7:0]; n = int'(addr[4:0]); hi = (lo >= 8'h80);
        if ((addr[11:8] == 4'hB || addr[11:8] == 4'hC) && (lo < 8'h20 || (lo >= 8'h80 && lo < 8'hA0)) && n != 1) begin
            leg = 1; is_cnt = 1;
            old = hi ? m_cnt[n][63:32] : m_cnt[n][31:0];
        end else if (addr >= 12'h320 && addr <= 12'h33F && n != 1 && n != 2) begin
            leg = 1;
            old = (n == 0) ? m_inh : m_evt[n];
        end
        if (wr && addr[11:8] == 4'hC) leg = 0;
        if (op == 2'b11) leg = 0;
        nv   = (op == 2'b00) ? wd : (op == 2'b01) ? (old | wd) : (old & ~wd);
        dowr = acc && wr && leg && (op == 2'b00 || wd != 0);

        for (int k = 0; k < 32; k++) inc[k] = 0;
        inc[0] = !m_inh[0];
        inc[2] = ir && !m_inh[2];
        for (int k = 3; k < 3 + NH; k++) begin
            e = int'(m_evt[k][4:0]);
            if (e >= 1 && e <= NE) inc[k] = ev[e - 1] && !m_inh[k];
        end

        @(posedge Clock);
        for (int k = 0; k < 32; k++) begin
            if (dowr && is_cnt && k == n && m_impl(k)) begin
                if (hi) m_cnt[k][63:32] = nv;
                else    m_cnt[k][31:0]  = nv;
            end else if (inc[k]) begin
                m_cnt[k] = m_cnt[k] + 64'd1;
            end
        end
        if (dowr && !is_cnt) begin
            if (n == 0) m_inh = nv & inh_mask;
            else if (m_impl(n)) m_evt[n] = nv & 32'h7FFF_FFFF;
        end
        #1;
        check("rd_valid", 32'(CsrRdValid), 32'(acc));
        if (acc) begin
            check("illegal", 32'(CsrIllegal), 32'(!leg));
            check("rd_data", CsrRdData, leg ? old : 32'd0);
        end
        check("hpm_irq", 32'(HpmIrq), 32'd0);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(0, 0, 2'b00, 12'h000, 32'd0, 0, '0);
    endtask

    logic [11:0] alist [22] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84,
                                12'hB1F, 12'hC00, 12'hC80, 12'hC02, 12'hC03, 12'hC84, 12'h320, 12'h323,
                                12'h324, 12'h33F, 12'hB01, 12'h321, 12'h7B0, 12'hC01};

    initial begin
        logic [31:0]   r_wd;
        logic [NE-1:0] r_ev;
        logic [1:0]    r_op;
        bit            r_rd, r_wr, r_ir;

        inh_mask = 32'h5;
        for (int k = 3; k < 3 + NH; k++) inh_mask[k] = 1'b1;

        Rst_N = 1'b0; CsrRdEn = 0; CsrWrEn = 0; CsrOp = 0; CsrAddr = 0; CsrWrData = 0;
        InstrRetired = 0; EventVec = '0;
        m_reset();
        #12;
        check("rst_data", CsrRdData, 32'd0);
        check("rst_valid", 32'(CsrRdValid), 32'd0);
        check("rst_illegal", 32'(CsrIllegal), 32'd0);
        check("rst_irq", 32'(HpmIrq), 32'd0);
        @(posedge Clock); #1;
        Rst_N = 1'b1;

        // Ten idle cycles, then mcycle reads 10.
        idle(10);
        step(1, 0, 2'b00, 12'hB00, 32'd0, 0, '0);
        check("mcycle_10", CsrRdData, 32'd10);

        // Carry from low into high half.
        step(1, 1, 2'b00, 12'hB80, 32'd0, 0, '0);
        step(1, 1, 2'b00, 12'hB00, 32'hFFFF_FFFF, 0, '0);
        idle(1);
        step(1, 0, 2'b00, 12'hB80, 32'd0, 0, '0);
        check("mcycle_carry_hi", CsrRdData, 32'd1);
        step(1, 0, 2'b00, 12'hC00, 32'd0, 0, '0);
        check("cycle_shadow_lo", CsrRdData, 32'd1);

        // Event selection and inhibit.
        step(0, 1, 2'b00, 12'h323, 32'd2, 0, '0);
        for (int p = 0; p < 5; p++) step(0, 0, 2'b00, 12'h000, 32'd0, 0, 8'b0000_0010);
        for (int p = 0; p < 3; p++) step(0, 0, 2'b00, 12'h000, 32'd0, 0, 8'b0000_0001);
        step(1, 0, 2'b00, 12'hB03, 32'd0, 0, '0);
        check("hpm3_count", CsrRdData, 32'd5);
        step(1, 1, 2'b01, 12'h320, 32'h8, 0, '0);
        for (int p = 0; p < 4; p++) step(0, 0, 2'b00, 12'h000, 32'd0, 0, 8'b0000_0010);
        step(1, 0, 2'b00, 12'hB03, 32'd0, 0, '0);
        check("hpm3_inhibited", CsrRdData, 32'd5);
        step(1, 1, 2'b10, 12'h320, 32'h8, 0, '0);

        // Write beats same-cycle retire.
        step(1, 1, 2'b00, 12'hB02, 32'd100, 1, '0);
        step(1, 0, 2'b00, 12'hB02, 32'd0, 1, '0);
        check("minstret_written", CsrRdData, 32'd100);
        step(1, 0, 2'b00, 12'hB02, 32'd0, 0, '0);
        check("minstret_plus1", CsrRdData, 32'd101);

        // Illegal and unimplemented-but-legal accesses.
        step(1, 1, 2'b00, 12'hC00, 32'd5, 0, '0);
        check("shadow_wr_illegal", 32'(CsrIllegal), 32'd1);
        step(1, 0, 2'b00, 12'hB1F, 32'd0, 0, '0);
        check("unimpl_rd_zero", CsrRdData, 32'd0);
        check("unimpl_legal", 32'(CsrIllegal), 32'd0);
        step(1, 0, 2'b00, 12'h7B0, 32'd0, 0, '0);
        check("bad_addr_illegal", 32'(CsrIllegal), 32'd1);
        step(1, 1, 2'b11, 12'hB00, 32'd7, 0, '0);
        check("bad_op_illegal", 32'(CsrIllegal), 32'd1);

        // Random traffic.
        for (int t = 0; t < 600; t++) begin
            r_rd = ($urandom_range(0, 9) < 7);
            r_wr = ($urandom_range(0, 9) < 4);
            r_op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       r_wd = $urandom;
                1:       r_wd = 32'($urandom_range(0, 10));
                2:       r_wd = 32'd0;
                default: r_wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            r_ev = NE'($urandom);
            r_ir = 1'($urandom);
            step(r_rd, r_wr, r_op, alist[$urandom_range(0, 21)], r_wd, r_ir, r_ev);
        end
        idle(1);

        // Reset in the middle of a response.
        CsrRdEn = 1; CsrWrEn = 0; CsrOp = 2'b00; CsrAddr = 12'hB00;
        @(posedge Clock); #1;
        CsrRdEn = 0;
        check("pre_rst_valid", 32'(CsrRdValid), 32'd1);
        Rst_N = 1'b0;
        #1;
        check("mid_rst_valid", 32'(CsrRdValid), 32'd0);
        check("mid_rst_data", CsrRdData, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
